// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and default sizing for the FFT stage controller
package fft_pkg;
    localparam int LOG2N_DEF    = 3;
    localparam int BFLY_LAT_DEF = 2;
    localparam int ADDR_W_DEF   = LOG2N_DEF;
    localparam int TW_W_DEF     = LOG2N_DEF - 1;
    localparam int STAGE_W_DEF  = $clog2(LOG2N_DEF);
    localparam int DRAIN_W      = 4;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fft_ctrl_pipe.sv
// fft_ctrl_pipe: stall-aware issue-to-writeback delay line for butterfly valid and addresses
module fft_ctrl_pipe
    import fft_pkg::*;
#(
    parameter int LAT = BFLY_LAT_DEF,
    parameter int AW  = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          stall,
    input  logic          in_v,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_v,
    output logic [AW-1:0] out_a,
    output logic [AW-1:0] out_b
);
    logic [LAT-1:0]         v;
    logic [LAT-1:0][AW-1:0] a, b;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v <= '0;
            a <= '0;
            b <= '0;
        end else if (!stall) begin
            v[0] <= in_v;
            a[0] <= in_a;
            b[0] <= in_b;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
                b[i] <= b[i-1];
            end
        end
    end

    assign out_v = v[LAT-1] & ~stall;
    assign out_a = a[LAT-1];
    assign out_b = b[LAT-1];
endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: radix-2 in-place FFT sequencer issuing butterfly addresses stage by stage
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int BFLY_LAT = BFLY_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     start,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b
);
    localparam int AW = LOG2N;
    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);

    state_t             state, state_nx;
    logic [SW-1:0]      s, s_nx, sh;
    logic [KW-1:0]      k, k_nx;
    logic [DRAIN_W-1:0] d, d_nx;
    logic [AW-1:0]      kk, span, pos, a_raw;
    logic               last_k, last_d, last_s;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            d     <= '0;
        end else begin
            state <= state_nx;
            s     <= s_nx;
            k     <= k_nx;
            d     <= d_nx;
        end
    end

    always_comb begin
        last_k   = k == {KW{1'b1}};
        last_d   = d == DRAIN_W'(BFLY_LAT - 1);
        last_s   = s == SW'(LOG2N - 1);
        state_nx = state;
        s_nx     = s;
        k_nx     = k;
        d_nx     = d;
        case (state)
            IDLE: if (start) begin
                state_nx = RUN;
                s_nx     = '0;
                k_nx     = '0;
            end
            RUN: if (!stall) begin
                state_nx = last_k ? DRAIN : RUN;
                k_nx     = last_k ? '0 : k + 1'b1;
                d_nx     = '0;
            end
            // drain lets the last writes of stage s land before stage s+1 reads
            DRAIN: if (!stall) begin
                d_nx = d + 1'b1;
                if (last_d) begin
                    state_nx = last_s ? DONE : RUN;
                    s_nx     = last_s ? s : s + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en  = state == RUN && !stall;
        kk     = AW'(k);
        span   = AW'(1) << s;
        pos    = kk & (span - 1'b1);
        a_raw  = ((kk & ~(span - 1'b1)) << 1) | pos;
        sh     = SW'(LOG2N - 1) - s;
        addr_a = rd_en ? a_raw : '0;
        addr_b = rd_en ? (a_raw | span) : '0;
        tw_idx = rd_en ? (AW-1)'(pos << sh) : '0;
        busy   = state == RUN || state == DRAIN;
        done   = state == DONE;
        stage  = s;
    end

    fft_ctrl_pipe #(.LAT(BFLY_LAT), .AW(AW)) u_pipe (
        .clk   (clk),
        .clr_n (clr_n),
        .stall (stall),
        .in_v  (rd_en),
        .in_a  (addr_a),
        .in_b  (addr_b),
        .out_v (wr_en),
        .out_a (wr_addr_a),
        .out_b (wr_addr_b)
    );
endmodule
